// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared types and helpers for the decode-stage operand select / hazard scoreboard.
// Forwarding source indices follow pipeline age: lower index is younger.
package id_hazard_scoreboard_pkg;

  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_LU,
    HZ_RAW,
    HZ_WAW,
    HZ_FULL
  } hazard_e;

  localparam int unsigned FWD_EX  = 0;
  localparam int unsigned FWD_MEM = 1;
  localparam int unsigned FWD_WB  = 2;

  // Width needed to index n items; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/id_hazard_scoreboard_operand_sel.sv
// Per-read-port operand mux: immediate, youngest forwarding hit, or regfile data.
// Also flags a load-use hazard when the selected forwarding source is not ready yet.
module operand_sel
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5,
  parameter int unsigned NFWD = 3
) (
  input  logic                 rd_ena,
  input  logic [AW-1:0]        rd_addr,
  input  logic [XLEN-1:0]      rf_data,
  input  logic [XLEN-1:0]      imm,
  input  logic [NFWD-1:0]      fwd_ena,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_rdy,
  output logic [XLEN-1:0]      opnd,
  output logic                 hz_lu,
  output logic                 hit
);

  // First hit in ascending order is the youngest; an older ready copy never
  // hides a younger producer whose data is still pending.
  always_comb begin
    opnd  = rf_data;
    hz_lu = 1'b0;
    hit   = 1'b0;
    if (!rd_ena) begin
      opnd = imm;
    end else if (rd_addr != '0) begin
      for (int unsigned j = FWD_EX; j < NFWD; j++) begin
        if (!hit && fwd_ena[j] && (fwd_addr[j*AW +: AW] == rd_addr)) begin
          hit   = 1'b1;
          opnd  = fwd_data[j*XLEN +: XLEN];
          hz_lu = ~fwd_rdy[j];
        end
      end
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage operand selection, issue stall generation and busy-bit scoreboard
// for in-flight long-latency register writes.
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter  int unsigned XLEN     = 64,
  parameter  int unsigned NREG     = 32,
  parameter  int unsigned NRD      = 2,
  parameter  int unsigned NFWD     = 3,
  parameter  int unsigned MAX_LONG = 4,
  parameter  int unsigned CNTW     = 32,
  localparam int unsigned AW       = clog2_min1(NREG),
  localparam int unsigned LCW      = clog2_min1(MAX_LONG + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NRD-1:0]       rd_ena,
  input  logic [NRD*AW-1:0]    rd_addr,
  input  logic [NRD*XLEN-1:0]  rf_data,
  input  logic [XLEN-1:0]      imm,
  input  logic [NFWD-1:0]      fwd_ena,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic                 issue_valid,
  input  logic                 issue_wena,
  input  logic [AW-1:0]        issue_waddr,
  input  logic                 issue_long,
  input  logic                 flush,
  input  logic                 long_done,
  input  logic [AW-1:0]        long_done_addr,
  output logic [NRD*XLEN-1:0]  opnd,
  output logic                 stall,
  output logic [NREG-1:0]      busy,
  output logic [LCW-1:0]       long_cnt,
  output logic [CNTW-1:0]      stall_cnt
);

  logic [NRD-1:0]  port_lu;
  logic [NRD-1:0]  port_hit;
  logic [NRD-1:0]  port_raw;
  logic            hz_waw;
  logic            hz_full;
  logic            accept;
  logic            set_eff;
  logic            clr_eff;
  hazard_e         cause;
  logic [NREG-1:0] busy_nxt;
  logic [LCW-1:0]  long_cnt_nxt;

  for (genvar k = 0; k < NRD; k++) begin : g_port
    operand_sel #(
      .XLEN (XLEN),
      .AW   (AW),
      .NFWD (NFWD)
    ) u_operand_sel (
      .rd_ena   (rd_ena[k]),
      .rd_addr  (rd_addr[k*AW +: AW]),
      .rf_data  (rf_data[k*XLEN +: XLEN]),
      .imm      (imm),
      .fwd_ena  (fwd_ena),
      .fwd_addr (fwd_addr),
      .fwd_data (fwd_data),
      .fwd_rdy  (fwd_rdy),
      .opnd     (opnd[k*XLEN +: XLEN]),
      .hz_lu    (port_lu[k]),
      .hit      (port_hit[k])
    );

    // A forwarding hit means the producer is still in the pipe with its data,
    // so the scoreboard bit is not the authority for this port.
    assign port_raw[k] = rd_ena[k] & busy[rd_addr[k*AW +: AW]]
                       & (rd_addr[k*AW +: AW] != '0) & ~port_hit[k];
  end

  // Any write to a busy register waits, so write order is preserved.
  assign hz_waw  = issue_wena & busy[issue_waddr];
  assign hz_full = issue_long & issue_wena & (long_cnt == LCW'(MAX_LONG));

  always_comb begin
    cause = HZ_NONE;
    if (|port_lu)       cause = HZ_LU;
    else if (|port_raw) cause = HZ_RAW;
    else if (hz_waw)    cause = HZ_WAW;
    else if (hz_full)   cause = HZ_FULL;
  end

  assign stall   = issue_valid & ~flush & (cause != HZ_NONE);
  assign accept  = issue_valid & ~flush & ~stall;
  assign set_eff = accept & issue_long & issue_wena & (issue_waddr != '0);
  assign clr_eff = long_done & busy[long_done_addr] & (long_done_addr != '0);

  // Set is applied after clear so a same-register collision leaves the bit set.
  always_comb begin
    busy_nxt     = busy;
    long_cnt_nxt = long_cnt;
    if (clr_eff) busy_nxt[long_done_addr] = 1'b0;
    if (set_eff) busy_nxt[issue_waddr]    = 1'b1;
    case ({set_eff, clr_eff})
      2'b10:   long_cnt_nxt = long_cnt + LCW'(1);
      2'b01:   long_cnt_nxt = long_cnt - LCW'(1);
      default: long_cnt_nxt = long_cnt;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy      <= '0;
      long_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      long_cnt <= long_cnt_nxt;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard: expected values are queued as stimulus
// is applied and popped when the corresponding DUT output is sampled.
module tb_id_hazard_scoreboard;

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 5;

  logic          clock;
  logic          reset;
  logic [1:0]    rd_ena;
  logic [9:0]    rd_addr;
  logic [127:0]  rf_data;
  logic [63:0]   imm;
  logic [2:0]    fwd_ena;
  logic [14:0]   fwd_addr;
  logic [191:0]  fwd_data;
  logic [2:0]    fwd_rdy;
  logic          issue_valid;
  logic          issue_wena;
  logic [4:0]    issue_waddr;
  logic          issue_long;
  logic          flush;
  logic          long_done;
  logic [4:0]    long_done_addr;
  logic [127:0]  opnd;
  logic          stall;
  logic [31:0]   busy;
  logic [2:0]    long_cnt;
  logic [3:0]    stall_cnt;

  id_hazard_scoreboard #(
    .XLEN     (64),
    .NREG     (32),
    .NRD      (2),
    .NFWD     (3),
    .MAX_LONG (4),
    .CNTW     (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .rd_ena         (rd_ena),
    .rd_addr        (rd_addr),
    .rf_data        (rf_data),
    .imm            (imm),
    .fwd_ena        (fwd_ena),
    .fwd_addr       (fwd_addr),
    .fwd_data       (fwd_data),
    .fwd_rdy        (fwd_rdy),
    .issue_valid    (issue_valid),
    .issue_wena     (issue_wena),
    .issue_waddr    (issue_waddr),
    .issue_long     (issue_long),
    .flush          (flush),
    .long_done      (long_done),
    .long_done_addr (long_done_addr),
    .opnd           (opnd),
    .stall          (stall),
    .busy           (busy),
    .long_cnt       (long_cnt),
    .stall_cnt      (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [3:0]  m_scnt  = '0;

  task automatic want(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic got(input logic [63:0] obs);
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL underflow: observed %0h with no expected value queued", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic set_rd(input int k, input logic e, input logic [4:0] a, input logic [63:0] d);
    rd_ena[k]              = e;
    rd_addr[k*AW +: AW]    = a;
    rf_data[k*XLEN +: XLEN] = d;
  endtask

  task automatic set_fwd(input int j, input logic e, input logic [4:0] a,
                         input logic [63:0] d, input logic r);
    fwd_ena[j]               = e;
    fwd_addr[j*AW +: AW]     = a;
    fwd_data[j*XLEN +: XLEN] = d;
    fwd_rdy[j]               = r;
  endtask

  task automatic set_issue(input logic v, input logic w, input logic l, input logic [4:0] a);
    issue_valid = v;
    issue_wena  = w;
    issue_long  = l;
    issue_waddr = a;
  endtask

  task automatic set_done(input logic d, input logic [4:0] a);
    long_done      = d;
    long_done_addr = a;
  endtask

  task automatic opchk(input string tag, input logic [63:0] e0, input logic [63:0] e1);
    want({tag, ".opnd0"}, e0);
    want({tag, ".opnd1"}, e1);
    #2;
    got(opnd[63:0]);
    got(opnd[127:64]);
  endtask

  // One clock: stall checked mid-cycle, registered state checked after the edge.
  task automatic cyc(input string tag, input logic st, input logic [31:0] b, input logic [2:0] c);
    want({tag, ".stall"}, 64'(st));
    @(negedge clock);
    got(64'(stall));
    if (st && (m_scnt != 4'hF)) m_scnt++;
    want({tag, ".busy"}, 64'(b));
    want({tag, ".long_cnt"}, 64'(c));
    want({tag, ".stall_cnt"}, 64'(m_scnt));
    @(posedge clock);
    #1;
    got(64'(busy));
    got(64'(long_cnt));
    got(64'(stall_cnt));
  endtask

  initial begin
    reset   = 1'b0;
    rd_ena  = '0; rd_addr  = '0; rf_data  = '0; imm     = '0;
    fwd_ena = '0; fwd_addr = '0; fwd_data = '0; fwd_rdy = '0;
    set_issue(1'b0, 1'b0, 1'b0, 5'd0);
    flush = 1'b0;
    set_done(1'b0, 5'd0);

    #1 reset = 1'b1;
    want("reset.busy", 64'd0); want("reset.long_cnt", 64'd0); want("reset.stall_cnt", 64'd0);
    #1;
    got(64'(busy)); got(64'(long_cnt)); got(64'(stall_cnt));
    @(posedge clock); #1;
    reset = 1'b0;

    // Forwarding priority and immediate substitution
    set_issue(1'b1, 1'b0, 1'b0, 5'd0);
    imm = 64'h1234;
    set_rd(0, 1'b1, 5'd5, 64'h111);
    set_rd(1, 1'b0, 5'd9, 64'h222);
    set_fwd(0, 1'b1, 5'd5, 64'hA, 1'b1);
    set_fwd(1, 1'b1, 5'd5, 64'hB, 1'b1);
    opchk("prio", 64'hA, 64'h1234);
    cyc("prio", 1'b0, 32'h0, 3'd0);
    set_fwd(0, 1'b0, 5'd5, 64'hA, 1'b1);
    opchk("older", 64'hB, 64'h1234);
    cyc("older", 1'b0, 32'h0, 3'd0);
    set_rd(1, 1'b1, 5'd0, 64'h0);
    set_fwd(2, 1'b1, 5'd0, 64'hCC, 1'b1);
    opchk("x0", 64'hB, 64'h0);
    cyc("x0", 1'b0, 32'h0, 3'd0);

    // Load-use: unready younger hit wins over ready older one
    fwd_ena = '0;
    set_rd(0, 1'b0, 5'd0, 64'h0);
    set_rd(1, 1'b1, 5'd7, 64'h777);
    set_fwd(0, 1'b1, 5'd7, 64'h70, 1'b0);
    set_fwd(1, 1'b1, 5'd7, 64'h71, 1'b1);
    opchk("lu", 64'h1234, 64'h70);
    cyc("lu", 1'b1, 32'h0, 3'd0);
    cyc("lu_hold", 1'b1, 32'h0, 3'd0);
    fwd_rdy[0] = 1'b1;
    opchk("lu_rdy", 64'h1234, 64'h70);
    cyc("lu_rdy", 1'b0, 32'h0, 3'd0);

    // Long-latency RAW on x9
    fwd_ena = '0;
    rd_ena  = '0;
    set_issue(1'b1, 1'b1, 1'b1, 5'd9);
    cyc("long9", 1'b0, 32'h200, 3'd1);
    set_issue(1'b1, 1'b0, 1'b0, 5'd0);
    set_rd(0, 1'b1, 5'd9, 64'h900);
    cyc("raw9", 1'b1, 32'h200, 3'd1);
    set_fwd(1, 1'b1, 5'd9, 64'h99, 1'b1);
    opchk("raw9_fwd", 64'h99, 64'h1234);
    cyc("raw9_fwd", 1'b0, 32'h200, 3'd1);
    fwd_ena = '0;
    set_done(1'b1, 5'd9);
    cyc("done9", 1'b1, 32'h0, 3'd0);
    set_done(1'b0, 5'd0);
    cyc("after9", 1'b0, 32'h0, 3'd0);

    // Fill the scoreboard, then a capacity stall overlapping a completion
    rd_ena = '0;
    set_issue(1'b1, 1'b1, 1'b1, 5'd1); cyc("fill1", 1'b0, 32'h02, 3'd1);
    set_issue(1'b1, 1'b1, 1'b1, 5'd2); cyc("fill2", 1'b0, 32'h06, 3'd2);
    set_issue(1'b1, 1'b1, 1'b1, 5'd3); cyc("fill3", 1'b0, 32'h0E, 3'd3);
    set_issue(1'b1, 1'b1, 1'b1, 5'd4); cyc("fill4", 1'b0, 32'h1E, 3'd4);
    set_issue(1'b1, 1'b1, 1'b1, 5'd5);
    set_done(1'b1, 5'd2);
    cyc("full", 1'b1, 32'h1A, 3'd3);
    set_done(1'b0, 5'd0);
    cyc("full_acc", 1'b0, 32'h3A, 3'd4);

    // Completion and reissue of the same register
    set_issue(1'b1, 1'b1, 1'b1, 5'd3);
    set_done(1'b1, 5'd3);
    cyc("waw3", 1'b1, 32'h32, 3'd3);
    set_done(1'b0, 5'd0);
    cyc("reissue3", 1'b0, 32'h3A, 3'd4);
    set_issue(1'b1, 1'b0, 1'b0, 5'd0);
    set_done(1'b1, 5'd4);
    cyc("done4", 1'b0, 32'h2A, 3'd3);
    set_issue(1'b1, 1'b1, 1'b1, 5'd7);
    set_done(1'b1, 5'd5);
    cyc("setclr", 1'b0, 32'h8A, 3'd3);
    set_issue(1'b1, 1'b1, 1'b1, 5'd0);
    set_done(1'b0, 5'd0);
    cyc("long_x0", 1'b0, 32'h8A, 3'd3);
    set_issue(1'b1, 1'b0, 1'b0, 5'd0);
    set_done(1'b1, 5'd20);
    cyc("done_idle", 1'b0, 32'h8A, 3'd3);
    set_done(1'b1, 5'd0);
    cyc("done_x0", 1'b0, 32'h8A, 3'd3);
    set_done(1'b0, 5'd0);

    // Flush masks a RAW stall and blocks the scoreboard set
    set_rd(0, 1'b1, 5'd7, 64'h700);
    set_issue(1'b1, 1'b1, 1'b1, 5'd8);
    flush = 1'b1;
    cyc("flush", 1'b0, 32'h8A, 3'd3);
    flush = 1'b0;
    cyc("raw7", 1'b1, 32'h8A, 3'd3);

    // Asynchronous reset between clock edges
    reset = 1'b1;
    m_scnt = '0;
    want("areset.busy", 64'd0); want("areset.long_cnt", 64'd0); want("areset.stall_cnt", 64'd0);
    #1;
    got(64'(busy)); got(64'(long_cnt)); got(64'(stall_cnt));
    #1 reset = 1'b0;
    set_issue(1'b1, 1'b0, 1'b0, 5'd0);
    cyc("post_reset", 1'b0, 32'h0, 3'd0);

    // Stall counter saturation
    set_fwd(0, 1'b1, 5'd7, 64'h70, 1'b0);
    for (int i = 0; i < 18; i++) cyc("sat", 1'b1, 32'h0, 3'd0);
    fwd_rdy[0] = 1'b1;
    cyc("sat_end", 1'b0, 32'h0, 3'd0);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL leftover: %0d expected values never compared, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
